// File: rtl/v5_peak_detector_pkg.sv
// Shared v5 filter-chain settings.
// Sample width, peak detector defaults and FSM state type.
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;

  localparam int V5_PD_THRESHOLD = 64;
  localparam int V5_PD_MAX_WIDTH = 255;
  localparam int V5_PD_DEAD_TIME = 32;

  typedef enum logic [1:0] {
    PD_IDLE,
    PD_ARMED,
    PD_DEAD
  } pd_state_t;

endpackage

// File: rtl/v5_peak_detector.sv
// v5 peak detector: threshold trigger, peak/time-to-peak capture,
// pile-up timeout, dead time and saturating event counter.
module v5_peak_detector
  import package_settings::*;
#(
  parameter int THRESHOLD = V5_PD_THRESHOLD,
  parameter int MAX_WIDTH = V5_PD_MAX_WIDTH,
  parameter int DEAD_TIME = V5_PD_DEAD_TIME,
  parameter int CNT_W     = 16,
  localparam int TW       = $clog2(MAX_WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [TW-1:0]               peak_time,
  output logic                               pileup,
  output logic        [CNT_W-1:0]            event_count,
  output logic                               busy
);

  localparam int W  = SIZE_FILTER_DATA;
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  localparam logic signed [W-1:0] TH        = W'(THRESHOLD);
  localparam logic [TW-1:0]       MW_LAST   = TW'(MAX_WIDTH - 1);
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_TIME - 1);
  localparam pd_state_t           AFTER_REP =
    (DEAD_TIME == 0) ? PD_IDLE : PD_DEAD;
  localparam logic                BUSY_REP  = (DEAD_TIME != 0);

  pd_state_t              state_q;
  logic signed [W-1:0]    in_q;
  logic signed [W-1:0]    max_q;
  logic        [TW-1:0]   tcnt_q;
  logic        [TW-1:0]   tpk_q;
  logic        [DW-1:0]   dcnt_q;
  logic                   pv_q;
  logic signed [W-1:0]    amp_q;
  logic        [TW-1:0]   ptime_q;
  logic                   pile_q;
  logic        [CNT_W-1:0] cnt_q;
  logic                   busy_q;

  logic [TW-1:0] tcnt_d;
  logic          end_below;
  logic          end_pile;
  logic          above_th;
  logic          above_max;

  assign tcnt_d    = tcnt_q + 1'b1;
  assign above_th  = (in_q > TH);
  assign end_below = !above_th;
  assign end_pile  = (tcnt_q == MW_LAST);
  assign above_max = (in_q > max_q);

  // Input register, detector FSM and report/statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PD_IDLE;
      in_q    <= '0;
      max_q   <= '0;
      tcnt_q  <= '0;
      tpk_q   <= '0;
      dcnt_q  <= '0;
      pv_q    <= 1'b0;
      amp_q   <= '0;
      ptime_q <= '0;
      pile_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      in_q <= input_data;
      pv_q <= 1'b0;
      unique case (state_q)
        PD_IDLE: begin
          if (above_th) begin
            state_q <= PD_ARMED;
            busy_q  <= 1'b1;
            max_q   <= in_q;
            tcnt_q  <= '0;
            tpk_q   <= '0;
          end
        end
        PD_ARMED: begin
          tcnt_q <= tcnt_d;
          if (end_below || end_pile) begin
            pv_q    <= 1'b1;
            amp_q   <= max_q;
            ptime_q <= tpk_q;
            pile_q  <= !end_below;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            state_q <= AFTER_REP;
            busy_q  <= BUSY_REP;
            dcnt_q  <= '0;
          end else if (above_max) begin
            max_q <= in_q;
            tpk_q <= tcnt_d;
          end
        end
        PD_DEAD: begin
          if (dcnt_q == DEAD_LAST) begin
            state_q <= PD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= PD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign peak_valid     = pv_q;
  assign peak_amplitude = amp_q;
  assign peak_time      = ptime_q;
  assign pileup         = pile_q;
  assign event_count    = cnt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_v5_peak_detector.sv
// Directed bench for v5_peak_detector.
// Second instance runs CNT_W=2, DEAD_TIME=0 for saturation.
module tb_v5_peak_detector;
  import package_settings::*;

  localparam int W = SIZE_FILTER_DATA;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] input_data;

  logic                pv;
  logic signed [W-1:0] amp;
  logic [7:0]          pt;
  logic                pile;
  logic [15:0]         cnt;
  logic                busy;

  logic                pv2;
  logic signed [W-1:0] amp2;
  logic [7:0]          pt2;
  logic                pile2;
  logic [1:0]          cnt2;
  logic                busy2;

  int n_chk  = 0;
  int n_pass = 0;

  v5_peak_detector dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .peak_valid     (pv),
    .peak_amplitude (amp),
    .peak_time      (pt),
    .pileup         (pile),
    .event_count    (cnt),
    .busy           (busy)
  );

  v5_peak_detector #(
    .DEAD_TIME (0),
    .CNT_W     (2)
  ) dut2 (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .peak_valid     (pv2),
    .peak_amplitude (amp2),
    .peak_time      (pt2),
    .pileup         (pile2),
    .event_count    (cnt2),
    .busy           (busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int v);
    input_data = W'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0);
  endtask

  task automatic wait_pv(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0);
      if (pv) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int rep;
  int rep_amp;
  int rep_pile;
  int seen;
  logic busy_dead;
  logic busy_after;

  initial begin
    reset      = 1'b1;
    input_data = '0;
    cyc(0);
    cyc(0);
    reset = 1'b0;
    chk("rst_pv", int'(pv), 0);
    chk("rst_amp", int'(amp), 0);
    chk("rst_time", int'(pt), 0);
    chk("rst_pile", int'(pile), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt2", int'(cnt2), 0);

    // single pulse
    cyc(0); cyc(0); cyc(70); cyc(100);
    cyc(150); cyc(120); cyc(80); cyc(60);
    chk("sp_pv_early", int'(pv), 0);
    cyc(0);
    chk("sp_pv", int'(pv), 1);
    chk("sp_amp", int'(amp), 150);
    chk("sp_time", int'(pt), 2);
    chk("sp_pile", int'(pile), 0);
    chk("sp_cnt", int'(cnt), 1);
    chk("sp_busy_dead", int'(busy), 1);
    cyc(0);
    chk("sp_pv_drop", int'(pv), 0);
    chk("sp_amp_hold", int'(amp), 150);
    idle(40);

    // threshold edge, negative input, ties
    cyc(64); cyc(0); cyc(0);
    chk("th64_busy", int'(busy), 0);
    cyc(-500); cyc(-500); cyc(0); cyc(0);
    chk("neg_busy", int'(busy), 0);
    chk("neg_cnt", int'(cnt), 1);
    cyc(65); cyc(90); cyc(90); cyc(10);
    cyc(0);
    chk("tie_pv", int'(pv), 1);
    chk("tie_amp", int'(amp), 90);
    chk("tie_time", int'(pt), 1);
    chk("tie_cnt", int'(cnt), 2);
    idle(40);

    // pile-up: 300 samples at 200
    rep       = 0;
    rep_amp   = 0;
    rep_pile  = 0;
    busy_dead = 1'b1;
    busy_after = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cyc(200);
      if (pv && rep == 0) begin
        rep      = i;
        rep_amp  = int'(amp);
        rep_pile = int'(pile);
      end
      if (rep != 0 && i >= rep && i <= rep + 31)
        busy_dead = busy_dead & busy;
      if (rep != 0 && i == rep + 32)
        busy_after = busy;
    end
    chk("pu_rep_cycle", rep, 257);
    chk("pu_amp", rep_amp, 200);
    chk("pu_pile", rep_pile, 1);
    chk("pu_busy_dead", int'(busy_dead), 1);
    chk("pu_busy_idle", int'(busy_after), 0);
    wait_pv(n);
    chk("pu2_lat", n, 2);
    chk("pu2_amp", int'(amp), 200);
    chk("pu2_time", int'(pt), 0);
    chk("pu2_pile", int'(pile), 0);
    chk("pu2_cnt", int'(cnt), 4);
    idle(40);

    // dead time
    cyc(100); cyc(100); cyc(0);
    wait_pv(n);
    chk("dt_lat", n, 1);
    chk("dt_cnt", int'(cnt), 5);
    idle(9);
    cyc(100); cyc(100); cyc(100);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0);
      if (pv) seen++;
    end
    chk("dt_ignored", seen, 0);
    chk("dt_cnt_hold", int'(cnt), 5);
    cyc(100); cyc(100); cyc(0);
    wait_pv(n);
    chk("dt2_lat", n, 1);
    idle(32);
    cyc(100); cyc(100); cyc(0);
    wait_pv(n);
    chk("dt33_lat", n, 1);
    chk("dt33_cnt", int'(cnt), 7);
    chk("dt33_cnt2", int'(cnt2), 3);
    idle(40);

    // reset mid-pulse
    cyc(120); cyc(120); cyc(120);
    chk("mr_armed", int'(busy), 1);
    reset = 1'b1;
    cyc(120);
    reset = 1'b0;
    chk("mr_pv", int'(pv), 0);
    chk("mr_amp", int'(amp), 0);
    chk("mr_time", int'(pt), 0);
    chk("mr_cnt", int'(cnt), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_cnt2", int'(cnt2), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0);
      if (pv || pv2) seen++;
    end
    chk("mr_no_pv", seen, 0);

    // saturation on the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      cyc(80);
      cyc(0);
      wait_pv(n);
      chk("sat_lat", n, 1);
      chk("sat_pv2", int'(pv2), 1);
      chk("sat_amp2", int'(amp2), 80);
      chk("sat_time2", int'(pt2), 0);
      chk("sat_pile2", int'(pile2), 0);
      chk("sat_busy2", int'(busy2), 0);
      chk("sat_cnt", int'(cnt), k + 1);
      chk("sat_cnt2", int'(cnt2), (k + 1 > 3) ? 3 : k + 1);
      idle(35);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
